// File: rtl/boundary_scan_register.sv
// Parametrised N-cell JTAG boundary-scan register with separate capture/shift/update stages.
// Optional BSR_TDO_NEGEDGE_EN: TDO is re-timed onto the falling edge of TCK.
module boundary_scan_register #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   OUTPUT_MASK = 8'hF0,
    parameter logic [WIDTH-1:0]   UPDATE_INIT = 8'h00
) (
    input  logic                           TCK,
    input  logic                           Reset,
    input  logic                           TestMode,
    input  logic                           CaptureDR,
    input  logic                           ShiftDR,
    input  logic                           UpdateDR,
    input  logic                           TDI,
    output logic                           TDO,
    input  logic [WIDTH-1:0]               PinIn,
    input  logic [WIDTH-1:0]               CoreIn,
    output logic [WIDTH-1:0]               CoreOut,
    output logic [WIDTH-1:0]               PinOut,
    output logic [$clog2(WIDTH+1)-1:0]     ShiftCount
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] ur_q;
    logic [WIDTH-1:0] ur_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Each cell samples the side it observes: core side for output cells, pad side for input cells.
    function automatic logic [WIDTH-1:0] capture_sel(
        input logic [WIDTH-1:0] pin_v,
        input logic [WIDTH-1:0] core_v
    );
        return (OUTPUT_MASK & core_v) | (~OUTPUT_MASK & pin_v);
    endfunction

    // Next-state for the shift register, update register and shift counter (capture > shift > update).
    always_comb begin
        sr_d  = sr_q;
        ur_d  = ur_q;
        cnt_d = cnt_q;
        if (CaptureDR) begin
            sr_d  = capture_sel(PinIn, CoreIn);
            cnt_d = '0;
        end else if (ShiftDR) begin
            sr_d = {TDI, sr_q[WIDTH-1:1]};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else if (UpdateDR) begin
            ur_d = sr_q;
        end else begin
            sr_d = sr_q;
        end
    end

    // Scan state registers with synchronous reset that overrides every control.
    always_ff @(posedge TCK) begin
        if (Reset) begin
            sr_q  <= '0;
            ur_q  <= UPDATE_INIT;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            ur_q  <= ur_d;
            cnt_q <= cnt_d;
        end
    end

    // Boundary outputs: UR drives in test mode, otherwise functional pass-through; unused direction tied low.
    always_comb begin
        if (TestMode) begin
            CoreOut = ~OUTPUT_MASK & ur_q;
            PinOut  =  OUTPUT_MASK & ur_q;
        end else begin
            CoreOut = ~OUTPUT_MASK & PinIn;
            PinOut  =  OUTPUT_MASK & CoreIn;
        end
    end

    assign ShiftCount = cnt_q;

`ifdef BSR_TDO_NEGEDGE_EN
    logic tdo_q;

    // Falling-edge re-time of the scan output so TDO settles half a cycle after SR.
    always_ff @(negedge TCK) begin
        if (Reset) begin
            tdo_q <= 1'b0;
        end else begin
            tdo_q <= sr_q[0];
        end
    end

    assign TDO = tdo_q;
`else
    assign TDO = sr_q[0];
`endif

endmodule
